// File: rtl/divider_pkg.sv
// Shared types and default widths for the restoring divider that sits beside the Booth multiplier.
package divider_pkg;

  localparam int DEFAULT_N = 6;
  localparam int DW = 2 * DEFAULT_N;
  localparam int CW = $clog2(2 * DEFAULT_N + 1);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    ITER,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration on magnitudes: shift {rem, quo} left and try to subtract |Y|.
module restoring_div_step #(
  parameter int N = 6
) (
  input  logic [N:0]     rem,
  input  logic [2*N-1:0] quo,
  input  logic [N:0]     absY,
  output logic [N:0]     remNext,
  output logic [2*N-1:0] quoNext
);

  logic [N+1:0] shifted;
  logic [N+1:0] trial;

  // rem < |Y| on entry, so the shifted value never reaches bit N+1 and trial's MSB is its sign
  always_comb begin
    shifted = {rem, quo[2*N-1]};
    trial   = shifted - {1'b0, absY};
    remNext = trial[N+1] ? shifted[N:0] : trial[N:0];
    quoNext = {quo[2*N-2:0], ~trial[N+1]};
  end

endmodule

// File: rtl/booth_divider.sv
// Sequential 2N/N restoring divider, one quotient bit per clock.
// Define DIVIDER_SIGNED_EN for two's-complement operands with truncating sign fix-up.
module booth_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [2*N-1:0] Z,
  input  logic [N-1:0]   Y,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int NW = 2 * N;
  localparam int NC = $clog2(2 * N + 1);

  state_t          state;
  logic [NW-1:0]   zReg;
  logic [N-1:0]    yReg;
  logic [N:0]      rem;
  logic [NW-1:0]   quo;
  logic [N:0]      absY;
  logic [NC-1:0]   cnt;
  logic [N:0]      remNext;
  logic [NW-1:0]   quoNext;
  logic [NW-1:0]   absZComb;
  logic [N:0]      absYComb;
  logic [N-1:0]    qOut;
  logic [N-1:0]    rOut;
  logic            ovfComb;

  restoring_div_step #(.N(N)) step (
    .rem     (rem),
    .quo     (quo),
    .absY    (absY),
    .remNext (remNext),
    .quoNext (quoNext)
  );

`ifdef DIVIDER_SIGNED_EN
  localparam logic [NW-1:0] POS_LIMIT = NW'((1 << (N - 1)) - 1);
  localparam logic [NW-1:0] NEG_LIMIT = NW'(1 << (N - 1));

  logic signQ;
  logic signR;

  // The most negative quotient has one more unit of magnitude than the most positive one
  always_comb begin
    absZComb = zReg[NW-1] ? -zReg : zReg;
    absYComb = yReg[N-1] ? -{yReg[N-1], yReg} : {yReg[N-1], yReg};
    qOut     = signQ ? -quo[N-1:0] : quo[N-1:0];
    rOut     = signR ? -rem[N-1:0] : rem[N-1:0];
    ovfComb  = signQ ? (quo > NEG_LIMIT) : (quo > POS_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      signQ <= 1'b0;
      signR <= 1'b0;
    end else if (state == ABS) begin
      signQ <= zReg[NW-1] ^ yReg[N-1];
      signR <= zReg[NW-1];
    end
  end
`else
  always_comb begin
    absZComb = zReg;
    absYComb = {1'b0, yReg};
    qOut     = quo[N-1:0];
    rOut     = rem[N-1:0];
    ovfComb  = |quo[NW-1:N];
  end
`endif

  // Control FSM; in DONE with busy still high we are finishing a divide-by-zero and raise done one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      zReg        <= '0;
      yReg        <= '0;
      rem         <= '0;
      quo         <= '0;
      absY        <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
          end else if (load) begin
            zReg        <= Z;
            yReg        <= Y;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b1;
            state       <= ABS;
          end
        end
        ABS: begin
          rem  <= '0;
          quo  <= absZComb;
          absY <= absYComb;
          cnt  <= NC'(NW);
          if (yReg == '0) begin
            div_by_zero <= 1'b1;
            Q           <= '0;
            R           <= '0;
            state       <= DONE;
          end else begin
            state <= ITER;
          end
        end
        ITER: begin
          rem <= remNext;
          quo <= quoNext;
          cnt <= cnt - NC'(1);
          if (cnt == NC'(1)) state <= FIX;
        end
        FIX: begin
          if (ovfComb) begin
            overflow <= 1'b1;
            Q        <= '0;
            R        <= '0;
          end else begin
            Q <= qOut;
            R <= rOut;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
